// File: rtl/axi4_ar_sender_mq.sv
// AR-channel sender for the RAB read path: forwards L1 hits, drops rejects and queues L1 misses
// in an L2_DEPTH-entry FIFO that is re-issued on the master AR port once L2 translates the head.
module axi4_ar_sender_mq #(
  parameter int unsigned AXI_ADDR_WIDTH = 40,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 4,
  parameter int unsigned L2_DEPTH       = 4,
  localparam int unsigned CNT_W         = $clog2(L2_DEPTH + 1)
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,

  input  logic                      l1_accept_i,
  input  logic                      l1_drop_i,
  input  logic                      l1_save_i,
  output logic                      l1_done_o,

  input  logic                      l2_accept_i,
  input  logic                      l2_drop_i,
  output logic                      l2_done_o,
  output logic                      l2_sending_o,
  output logic                      l2_pending_o,
  output logic                      l2_full_o,
  output logic [CNT_W-1:0]          l2_count_o,
  output logic                      l2_err_o,

  input  logic [AXI_ADDR_WIDTH-1:0] l1_araddr_i,
  input  logic [AXI_ADDR_WIDTH-1:0] l2_araddr_i,

  input  logic [AXI_ID_WIDTH-1:0]   s_axi4_arid,
  input  logic                      s_axi4_arvalid,
  output logic                      s_axi4_arready,
  input  logic [7:0]                s_axi4_arlen,
  input  logic [2:0]                s_axi4_arsize,
  input  logic [1:0]                s_axi4_arburst,
  input  logic                      s_axi4_arlock,
  input  logic [2:0]                s_axi4_arprot,
  input  logic [3:0]                s_axi4_arcache,
  input  logic [3:0]                s_axi4_arregion,
  input  logic [3:0]                s_axi4_arqos,
  input  logic [AXI_USER_WIDTH-1:0] s_axi4_aruser,

  output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
  output logic                      m_axi4_arvalid,
  input  logic                      m_axi4_arready,
  output logic [7:0]                m_axi4_arlen,
  output logic [2:0]                m_axi4_arsize,
  output logic [1:0]                m_axi4_arburst,
  output logic                      m_axi4_arlock,
  output logic [2:0]                m_axi4_arprot,
  output logic [3:0]                m_axi4_arcache,
  output logic [3:0]                m_axi4_arregion,
  output logic [3:0]                m_axi4_arqos,
  output logic [AXI_USER_WIDTH-1:0] m_axi4_aruser
);

  localparam int unsigned PTR_W   = $clog2(L2_DEPTH);
  localparam int unsigned ENTRY_W = AXI_ID_WIDTH + 29 + AXI_USER_WIDTH;

  logic [ENTRY_W-1:0] entry_q [L2_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;

  logic [ENTRY_W-1:0] s_entry, head;
  logic               save, l2_sent, pop;

  logic [AXI_ID_WIDTH-1:0]   h_id;
  logic [7:0]                h_len;
  logic [2:0]                h_size;
  logic [1:0]                h_burst;
  logic                      h_lock;
  logic [2:0]                h_prot;
  logic [3:0]                h_cache, h_region, h_qos;
  logic [AXI_USER_WIDTH-1:0] h_user;

  assign s_entry = {s_axi4_arid, s_axi4_arlen, s_axi4_arsize, s_axi4_arburst, s_axi4_arlock,
                    s_axi4_arprot, s_axi4_arcache, s_axi4_arregion, s_axi4_arqos, s_axi4_aruser};
  assign head    = entry_q[rd_ptr_q];
  assign {h_id, h_len, h_size, h_burst, h_lock, h_prot, h_cache, h_region, h_qos, h_user} = head;

  assign l2_pending_o = (count_q != '0);
  assign l2_full_o    = (count_q == CNT_W'(L2_DEPTH));
  assign l2_count_o   = count_q;
  assign l2_err_o     = err_q;

  // Drop wins over accept, so a double verdict never drives the master port.
  assign save         = l1_save_i & s_axi4_arvalid & ~l2_full_o;
  assign l2_sending_o = l2_accept_i & ~l2_drop_i & l2_pending_o;
  assign l2_sent      = l2_sending_o & m_axi4_arready;
  assign pop          = l2_sent | (l2_drop_i & l2_pending_o);
  assign l2_done_o    = pop;

  assign m_axi4_arvalid = (s_axi4_arvalid & l1_accept_i) | l2_sending_o;
  assign s_axi4_arready = (m_axi4_arvalid & m_axi4_arready & ~l2_sending_o) |
                          (s_axi4_arvalid & (l1_drop_i | save));
  assign l1_done_o      = s_axi4_arvalid & s_axi4_arready;

  always_comb begin
    m_axi4_araddr   = l1_araddr_i;
    m_axi4_arid     = s_axi4_arid;
    m_axi4_arlen    = s_axi4_arlen;
    m_axi4_arsize   = s_axi4_arsize;
    m_axi4_arburst  = s_axi4_arburst;
    m_axi4_arlock   = s_axi4_arlock;
    m_axi4_arprot   = s_axi4_arprot;
    m_axi4_arcache  = s_axi4_arcache;
    m_axi4_arregion = s_axi4_arregion;
    m_axi4_arqos    = s_axi4_arqos;
    m_axi4_aruser   = s_axi4_aruser;
    if (l2_sending_o) begin
      m_axi4_araddr   = l2_araddr_i;
      m_axi4_arid     = h_id;
      m_axi4_arlen    = h_len;
      m_axi4_arsize   = h_size;
      m_axi4_arburst  = h_burst;
      m_axi4_arlock   = h_lock;
      m_axi4_arprot   = h_prot;
      m_axi4_arcache  = h_cache;
      m_axi4_arregion = h_region;
      m_axi4_arqos    = h_qos;
      m_axi4_aruser   = h_user;
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      for (int i = 0; i < L2_DEPTH; i++) entry_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (save) begin
        entry_q[wr_ptr_q] <= s_entry;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (save && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !save) count_q <= count_q - 1'b1;
      if (((l2_drop_i | l2_accept_i) & ~l2_pending_o) | (l2_accept_i & l2_drop_i)) err_q <= 1'b1;
    end
  end

endmodule
